hc595_rx: RTL and testbench
===========================

HC595_RX -- requirements
Module: hc595_rx

Interface
REQ-001 The block SHALL have these parameters:
- FRAME_BITS, 16, bits per frame.
- SYNC_STAGES, 2, synchronizer flops per serial input.
- IDLE_TIMEOUT, 1024, clk cycles without an sh_cp/st_cp edge before a partial frame is aborted.

REQ-002 The block SHALL have these ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- sh_cp  in  1  serial shift clock; asynchronous to clk.
- st_cp  in  1  storage/latch clock; asynchronous to clk.
- ds  in  1  serial data; asynchronous to clk.
- frame_data  out  16  last good frame {dp, seg[6:0], sel[7:0]}.
- frame_valid  out  1  one-cycle pulse when a good frame is latched.
- frame_err  out  1  one-cycle pulse when a frame is latched with the wrong bit count.
- sel_err  out  1  one-cycle pulse when a good frame's sel is not active-low one-hot.
- digit_val  out  32  decoded hex nibble per digit; digit i occupies [4i+3:4i].
- digit_ok  out  8  digit i holds a recognised segment pattern.

Function
REQ-003 The block SHALL pass sh_cp, st_cp and ds each through SYNC_STAGES flops before use; all rising-edge detection SHALL use the synchronized value versus its previous value.
REQ-004 On each synchronized sh_cp rising edge, the block SHALL shift synchronized ds into the LSB of a 16-bit shift register, so the first bit received is the MSB.
REQ-005 Each synchronized sh_cp rising edge SHALL increment bit_cnt, which saturates at 31.
REQ-006 The FSM SHALL have states IDLE, SHIFT, LATCH and DECODE.
- IDLE -> SHIFT on the first sh_cp edge.
- SHIFT -> LATCH on an st_cp edge.
- LATCH -> DECODE on a good frame; LATCH -> IDLE on a bad frame.
- DECODE -> IDLE unconditionally.
- An st_cp edge in IDLE SHALL go directly to LATCH with bit_cnt=0.
REQ-007 In LATCH, if bit_cnt==FRAME_BITS, the block SHALL copy the shift register to frame_data and pulse frame_valid for exactly 1 cycle.
REQ-008 In LATCH, if bit_cnt!=FRAME_BITS (including 0 and >16), the block SHALL pulse frame_err for 1 cycle and leave frame_data unchanged.
REQ-009 On exit from LATCH, bit_cnt SHALL be cleared; the shift register SHALL be retained.
REQ-010 Latency SHALL be fixed: frame_valid/frame_err asserts 1 cycle after the cycle in which the st_cp rising edge is detected.
REQ-011 If sh_cp and st_cp rising edges are detected in the same cycle, the shift SHALL occur first, and LATCH SHALL evaluate the post-shift register and count.
REQ-012 If an sh_cp edge arrives during LATCH or DECODE, it SHALL still be shifted and counted, and it counts toward the next frame.
REQ-013 In SHIFT, if no sh_cp or st_cp edge occurs for IDLE_TIMEOUT consecutive cycles, the block SHALL clear bit_cnt and the shift register, return to IDLE, and assert no output pulse.
REQ-014 In DECODE, the block SHALL use frame_data sel[7:0] (active-low) and seg[6:0] (active-low, seg[6]=g ... seg[0]=a); bit 15 (dp) SHALL be ignored.
REQ-015 If sel has exactly one zero bit i, the block SHALL write digit i:
- Decode seg per this table: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- On a match: digit_val nibble i = value, digit_ok[i]=1.
- Otherwise (including blank 7F): nibble i = 0, digit_ok[i]=0.
- All other digits SHALL be unchanged.
REQ-016 If sel is not active-low one-hot, the block SHALL pulse sel_err for 1 cycle during DECODE and change no digit.
REQ-017 digit_val/digit_ok SHALL update exactly 1 cycle after frame_valid.

Reset
REQ-018 While reset is high at a clk edge, the block SHALL set:
- synchronizers and edge-history flops to 0;
- shift register and bit_cnt to 0;
- frame_data=16'h0000, digit_val=32'h0, digit_ok=8'h00;
- frame_valid, frame_err, sel_err to 0;
- FSM to IDLE.
REQ-019 Reset asserted mid-frame SHALL discard the partial frame; the first sh_cp edge after reset deasserts SHALL be treated as bit 15 of a new frame.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Good frame: 16 bits of 0xC0FE then st_cp -> frame_valid 1 cycle, frame_data=C0FE, next cycle digit_val[3:0]=0 and digit_ok[0]=1, all other digits unchanged.
- Second frame: 0xF9FD after the first -> digit_val[7:4]=1, digit_ok[1]=1, digit 0 still 0/ok.
- Short and long frames: 15 bits then st_cp -> frame_err 1 cycle, frame_data unchanged; 17 bits -> frame_err; st_cp with 0 bits -> frame_err.
- Bad sel: frame 0xC0FC -> frame_valid, then sel_err 1 cycle, digit_val/digit_ok unchanged; blank frame 0xFFFE -> digit_ok[0]=0, nibble 0 = 0.
- Timeout: 8 bits, idle 1024 cycles, then a full 0xC0FE frame -> frame_valid with frame_data=C0FE, no frame_err.
- Reset and simultaneous edges: reset after 10 bits, then a full frame -> frame_valid with correct data; 16th sh_cp edge coincident with the st_cp edge -> frame_valid.

Source files
------------

// File: rtl/hc595_rx.sv
// rtl/hc595_rx.sv - receiver for a 74HC595-style serial display stream with 7-segment digit decode
// Samples sh_cp/st_cp/ds asynchronously, frames 16-bit words and decodes per-digit hex values.

module hc595_rx #(
    parameter int FRAME_BITS   = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sh_cp,
    input  logic        st_cp,
    input  logic        ds,
    output logic [15:0] frame_data,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        sel_err,
    output logic [31:0] digit_val,
    output logic [7:0]  digit_ok
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_LATCH  = 2'd2;
    localparam logic [1:0] ST_DECODE = 2'd3;

    localparam int IW = $clog2(IDLE_TIMEOUT);

    logic [SYNC_STAGES-1:0] sh_sync;
    logic [SYNC_STAGES-1:0] st_sync;
    logic [SYNC_STAGES-1:0] ds_sync;
    logic                   sh_prev;
    logic                   st_prev;
    logic                   sh_s;
    logic                   st_s;
    logic                   ds_s;
    logic                   sh_rise;
    logic                   st_rise;

    logic [1:0]    state;
    logic [15:0]   shift_reg;
    logic [15:0]   shift_next;
    logic [4:0]    bit_cnt;
    logic [4:0]    cnt_next;
    logic          frame_good;
    logic [IW-1:0] idle_cnt;
    logic          timeout;

    logic [7:0]    sel_n;
    logic          sel_onehot;
    logic [3:0]    seg_val;
    logic          seg_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_sync <= '0;
            st_sync <= '0;
            ds_sync <= '0;
            sh_prev <= 1'b0;
            st_prev <= 1'b0;
        end else begin
            sh_sync <= {sh_sync[SYNC_STAGES-2:0], sh_cp};
            st_sync <= {st_sync[SYNC_STAGES-2:0], st_cp};
            ds_sync <= {ds_sync[SYNC_STAGES-2:0], ds};
            sh_prev <= sh_s;
            st_prev <= st_s;
        end
    end

    assign sh_s    = sh_sync[SYNC_STAGES-1];
    assign st_s    = st_sync[SYNC_STAGES-1];
    assign ds_s    = ds_sync[SYNC_STAGES-1];
    assign sh_rise = sh_s & ~sh_prev;
    assign st_rise = st_s & ~st_prev;

    // The latch decision looks at the post-shift word so a coincident last bit is included.
    always_comb begin
        shift_next = shift_reg;
        cnt_next   = bit_cnt;
        if (sh_rise) begin
            shift_next = {shift_reg[14:0], ds_s};
            cnt_next   = (bit_cnt == 5'd31) ? 5'd31 : bit_cnt + 5'd1;
        end
    end

    assign frame_good = (cnt_next == 5'(FRAME_BITS));
    assign timeout    = (state == ST_SHIFT) && !sh_rise && !st_rise &&
                        (idle_cnt == IW'(IDLE_TIMEOUT - 1));

    assign sel_n      = ~frame_data[7:0];
    assign sel_onehot = (sel_n != 8'd0) && ((sel_n & (sel_n - 8'd1)) == 8'd0);

    always_comb begin
        seg_ok  = 1'b1;
        seg_val = 4'h0;
        case (frame_data[14:8])
            7'h40: seg_val = 4'h0;
            7'h79: seg_val = 4'h1;
            7'h24: seg_val = 4'h2;
            7'h30: seg_val = 4'h3;
            7'h19: seg_val = 4'h4;
            7'h12: seg_val = 4'h5;
            7'h02: seg_val = 4'h6;
            7'h78: seg_val = 4'h7;
            7'h00: seg_val = 4'h8;
            7'h10: seg_val = 4'h9;
            7'h08: seg_val = 4'hA;
            7'h03: seg_val = 4'hB;
            7'h46: seg_val = 4'hC;
            7'h21: seg_val = 4'hD;
            7'h06: seg_val = 4'hE;
            7'h0E: seg_val = 4'hF;
            default: begin
                seg_ok  = 1'b0;
                seg_val = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            shift_reg   <= 16'h0000;
            bit_cnt     <= 5'd0;
            idle_cnt    <= '0;
            frame_data  <= 16'h0000;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            sel_err     <= 1'b0;
            digit_val   <= 32'h0;
            digit_ok    <= 8'h00;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            sel_err     <= 1'b0;
            shift_reg   <= shift_next;
            bit_cnt     <= cnt_next;
            idle_cnt    <= '0;

            case (state)
                ST_IDLE, ST_SHIFT: begin
                    if (st_rise) begin
                        state <= ST_LATCH;
                        if (frame_good) begin
                            frame_data  <= shift_next;
                            frame_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (timeout) begin
                        state     <= ST_IDLE;
                        shift_reg <= 16'h0000;
                        bit_cnt   <= 5'd0;
                    end else if (sh_rise) begin
                        state <= ST_SHIFT;
                    end else if (state == ST_SHIFT) begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                ST_LATCH: begin
                    // An edge arriving here already belongs to the next frame.
                    bit_cnt <= {4'd0, sh_rise};
                    if (frame_valid) begin
                        state <= ST_DECODE;
                        if (sel_onehot) begin
                            for (int i = 0; i < 8; i++) begin
                                if (sel_n[i]) begin
                                    digit_val[4*i +: 4] <= seg_val;
                                    digit_ok[i]         <= seg_ok;
                                end
                            end
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hc595_rx.sv
// tb/tb_hc595_rx.sv - self-checking bench for hc595_rx
// Directed vector table, hand sequences for timeout/reset/coincident edges, then random frames.

module tb_hc595_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        sh_cp;
    logic        st_cp;
    logic        ds;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic        sel_err;
    logic [31:0] digit_val;
    logic [7:0]  digit_ok;

    int n_pass = 0;
    int n_chk  = 0;

    hc595_rx #(.FRAME_BITS(16), .SYNC_STAGES(2), .IDLE_TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .sh_cp(sh_cp), .st_cp(st_cp), .ds(ds),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
        .sel_err(sel_err), .digit_val(digit_val), .digit_ok(digit_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          exp_v;
        int          exp_e;
        int          exp_s;
        logic [15:0] exp_fd;
        logic [31:0] exp_dv;
        logic [7:0]  exp_dok;
    } vec_t;

    vec_t vecs[7];

    logic [6:0] seg_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ds = b;
        repeat (2) @(negedge clk);
        sh_cp = 1'b1;
        repeat (3) @(negedge clk);
        sh_cp = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // Raise st_cp (optionally together with a final sh_cp edge) and watch the pulse window.
    task automatic do_latch(input string name, input bit with_bit, input logic bit_val,
                            input int exp_v, input int exp_e, input int exp_s,
                            input logic [15:0] exp_fd,
                            input logic [31:0] old_dv, input logic [7:0] old_dok,
                            input logic [31:0] new_dv, input logic [7:0] new_dok);
        int nv = 0;
        int ne = 0;
        int ns = 0;
        int vidx = -1;
        logic [31:0] dv_at = '0;
        logic [31:0] dv_after = '0;
        logic [7:0]  ok_at = '0;
        logic [7:0]  ok_after = '0;
        @(negedge clk);
        if (with_bit) begin
            ds = bit_val;
            repeat (2) @(negedge clk);
            sh_cp = 1'b1;
        end
        st_cp = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (frame_valid) begin
                nv++;
                if (vidx < 0) begin
                    vidx  = c;
                    dv_at = digit_val;
                    ok_at = digit_ok;
                end
            end
            if (vidx >= 0 && c == vidx + 1) begin
                dv_after = digit_val;
                ok_after = digit_ok;
            end
            ne += int'(frame_err);
            ns += int'(sel_err);
            if (c == 4) begin
                sh_cp = 1'b0;
                st_cp = 1'b0;
            end
        end
        check({name, " valid_pulses"}, nv, exp_v);
        check({name, " err_pulses"}, ne, exp_e);
        check({name, " sel_err_pulses"}, ns, exp_s);
        check({name, " frame_data"}, {16'h0, frame_data}, {16'h0, exp_fd});
        check({name, " digit_val"}, digit_val, new_dv);
        check({name, " digit_ok"}, {24'h0, digit_ok}, {24'h0, new_dok});
        if (exp_v != 0) begin
            check({name, " dv_at_valid"}, dv_at, old_dv);
            check({name, " ok_at_valid"}, {24'h0, ok_at}, {24'h0, old_dok});
            check({name, " dv_after_valid"}, dv_after, new_dv);
            check({name, " ok_after_valid"}, {24'h0, ok_after}, {24'h0, new_dok});
        end
    endtask

    // Reference model: apply one good frame to the digit state from the decode rules.
    task automatic model_frame(input logic [15:0] f, inout logic [31:0] dv, inout logic [7:0] dok,
                               output int s_err);
        int zeros = 0;
        int idx = 0;
        int val = -1;
        for (int i = 0; i < 8; i++) if (f[i] == 1'b0) begin zeros++; idx = i; end
        if (zeros != 1) begin
            s_err = 1;
            return;
        end
        s_err = 0;
        for (int d = 0; d < 16; d++) if (seg_tab[d] == f[14:8]) val = d;
        if (val >= 0) begin
            dv[4*idx +: 4] = 4'(val);
            dok[idx] = 1'b1;
        end else begin
            dv[4*idx +: 4] = 4'h0;
            dok[idx] = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] prev_dv;
        logic [7:0]  prev_dok;
        logic [15:0] m_fd;
        logic [31:0] m_dv;
        logic [7:0]  m_dok;
        logic        bits_q[$];

        vecs[0] = '{32'hC0FE,  16, 1, 0, 0, 16'hC0FE, 32'h00, 8'h01};
        vecs[1] = '{32'hF9FD,  16, 1, 0, 0, 16'hF9FD, 32'h10, 8'h03};
        vecs[2] = '{32'h1234,  15, 0, 1, 0, 16'hF9FD, 32'h10, 8'h03};
        vecs[3] = '{32'h1C0FE, 17, 0, 1, 0, 16'hF9FD, 32'h10, 8'h03};
        vecs[4] = '{32'h0,      0, 0, 1, 0, 16'hF9FD, 32'h10, 8'h03};
        vecs[5] = '{32'hC0FC,  16, 1, 0, 1, 16'hC0FC, 32'h10, 8'h03};
        vecs[6] = '{32'hFFFE,  16, 1, 0, 0, 16'hFFFE, 32'h10, 8'h02};

        reset = 1'b1; sh_cp = 1'b0; st_cp = 1'b0; ds = 1'b0;
        repeat (4) @(negedge clk);
        check("reset frame_data", {16'h0, frame_data}, 32'h0);
        check("reset digit_val", digit_val, 32'h0);
        check("reset digit_ok", {24'h0, digit_ok}, 32'h0);
        check("reset pulses", {29'h0, frame_valid, frame_err, sel_err}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        prev_dv = 32'h0;
        prev_dok = 8'h00;
        for (int v = 0; v < 7; v++) begin
            send_bits(vecs[v].word, vecs[v].nbits);
            do_latch($sformatf("vec%0d", v), 1'b0, 1'b0, vecs[v].exp_v, vecs[v].exp_e,
                     vecs[v].exp_s, vecs[v].exp_fd, prev_dv, prev_dok,
                     vecs[v].exp_dv, vecs[v].exp_dok);
            prev_dv = vecs[v].exp_dv;
            prev_dok = vecs[v].exp_dok;
            repeat (3) @(negedge clk);
        end

        send_bits(32'hAB, 8);
        repeat (1030) @(negedge clk);
        send_bits(32'hC0FE, 16);
        do_latch("timeout", 1'b0, 1'b0, 1, 0, 0, 16'hC0FE, 32'h10, 8'h02, 32'h10, 8'h03);
        repeat (3) @(negedge clk);

        send_bits(32'hF9FD >> 1, 15);
        do_latch("coincident", 1'b1, 1'b1, 1, 0, 0, 16'hF9FD, 32'h10, 8'h03, 32'h10, 8'h03);
        repeat (3) @(negedge clk);

        send_bits(32'h3FF, 10);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset frame_data", {16'h0, frame_data}, 32'h0);
        check("midreset digit_ok", {24'h0, digit_ok}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send_bits(32'hC0FE, 16);
        do_latch("after_reset", 1'b0, 1'b0, 1, 0, 0, 16'hC0FE, 32'h0, 8'h00, 32'h0, 8'h01);
        repeat (3) @(negedge clk);

        m_fd = 16'hC0FE;
        m_dv = 32'h0;
        m_dok = 8'h01;
        for (int r = 0; r < 30; r++) begin
            int          sel_r;
            int          nb;
            int          ev;
            int          es;
            logic [15:0] w;
            logic [31:0] old_dv;
            logic [7:0]  old_dok;
            sel_r = $urandom_range(0, 9);
            nb = (sel_r == 0) ? 15 : (sel_r == 1) ? 17 : (sel_r == 2) ? 0 : 16;
            w[15] = 1'($urandom_range(0, 1));
            w[14:8] = ($urandom_range(0, 9) < 7) ? seg_tab[$urandom_range(0, 15)]
                                                 : 7'($urandom_range(0, 127));
            w[7:0] = ($urandom_range(0, 9) < 7) ? (8'hFF ^ (8'd1 << $urandom_range(0, 7)))
                                                : 8'($urandom_range(0, 255));
            bits_q.delete();
            for (int i = nb - 1; i >= 0; i--) bits_q.push_back((i < 16) ? w[i] : 1'b1);
            old_dv = m_dv;
            old_dok = m_dok;
            ev = (bits_q.size() == 16) ? 1 : 0;
            es = 0;
            if (ev != 0) begin
                for (int i = 0; i < 16; i++) m_fd[15 - i] = bits_q[i];
                model_frame(m_fd, m_dv, m_dok, es);
            end
            for (int i = 0; i < bits_q.size(); i++) send_bit(bits_q[i]);
            do_latch($sformatf("rand%0d", r), 1'b0, 1'b0, ev, 1 - ev, es, m_fd,
                     old_dv, old_dok, m_dv, m_dok);
            repeat (3) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
